// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order ALU issue FIFO with registered operand outputs and result-valid tracking.
// Optional opcode legality filter enabled by defining ALU_ISSUE_OPCHK_EN.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_opcode,
  input  logic [7:0]                 in_a,
  input  logic [7:0]                 in_b,
  output logic [3:0]                 alu_opcode,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic                       res_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       illegal_op
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [19:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic iss;
  logic [ALU_LAT-1:0] sr;
  logic pop, accept, bad, push;
  assign in_ready = !rst && !flush && (count < CW'(DEPTH));
  assign pop      = (count != '0) && !flush;
  assign accept   = in_valid && in_ready;
`ifdef ALU_ISSUE_OPCHK_EN
  assign bad = in_opcode > 4'd4;
`else
  assign bad = 1'b0;
`endif
  assign push      = accept && !bad;
  assign res_valid = sr[ALU_LAT-1];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_opcode, in_a, in_b};
  // iss marks a real instruction in the alu_* registers; sr tracks it through the ALU
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      {alu_opcode, alu_a, alu_b} <= {4'hF, 16'h0};
      iss <= 1'b0;
      sr <= '0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      {alu_opcode, alu_a, alu_b} <= {4'hF, 16'h0};
      iss <= 1'b0;
      sr <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      {alu_opcode, alu_a, alu_b} <= pop ? mem[rd_ptr] : {4'hF, 16'h0};
      iss <= pop;
      sr <= ALU_LAT'({sr, iss});
      illegal_op <= accept && bad;
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: randomized and directed checks of alu_issue_queue against a queue-based reference model.
// Honors ALU_ISSUE_OPCHK_EN when the design is built with it.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int ALU_LAT = 3;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0;
  logic in_ready, res_valid, illegal_op;
  logic [3:0] in_opcode = 0, alu_opcode;
  logic [7:0] in_a = 0, in_b = 0, alu_a, alu_b;
  logic [$clog2(DEPTH):0] count;
  int n_cmp = 0, n_bad = 0;
  logic [19:0] q [$];
  logic pv [$];
  logic [7:0] pr [$];
  logic [19:0] m_alu;
  logic m_ill, exp_v;
  logic [7:0] exp_r;
  logic [7:0] alu_pipe [ALU_LAT];

  alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .res_valid(res_valid), .count(count), .illegal_op(illegal_op));

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [19:0] x);
    logic [7:0] a, b;
    a = x[15:8];
    b = x[7:0];
    case (x[19:16])
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  // Downstream ALU stand-in: captures operands one edge after issue, result ALU_LAT edges after issue
  always @(posedge clk) begin
    for (int i = ALU_LAT - 1; i > 0; i--) alu_pipe[i] <= alu_pipe[i-1];
    alu_pipe[0] <= alu_f({alu_opcode, alu_a, alu_b});
  end

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pv.delete();
    pr.delete();
    for (int i = 0; i < ALU_LAT; i++) begin
      pv.push_back(1'b0);
      pr.push_back(8'h00);
    end
    m_alu = {4'hF, 16'h0};
    m_ill = 0;
    exp_v = 0;
    exp_r = 0;
  endtask

  task automatic cycle(logic v, logic [3:0] op, logic [7:0] a, logic [7:0] b, logic fl);
    logic rdy, acc, legal, pop;
    @(negedge clk);
    in_valid = v;
    in_opcode = op;
    in_a = a;
    in_b = b;
    flush = fl;
    rdy = !fl && (q.size() < DEPTH);
    #1 check("in_ready", in_ready, rdy);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      acc = v && rdy;
`ifdef ALU_ISSUE_OPCHK_EN
      legal = op <= 4'd4;
`else
      legal = 1'b1;
`endif
      pop = q.size() > 0;
      m_alu = pop ? q.pop_front() : {4'hF, 16'h0};
      if (acc && legal) q.push_back({op, a, b});
      m_ill = acc && !legal;
      pv.push_back(pop);
      pr.push_back(alu_f(m_alu));
      exp_v = pv.pop_front();
      exp_r = pr.pop_front();
    end
    #1;
    check("count", count, q.size());
    check("alu_ops", {alu_opcode, alu_a, alu_b}, m_alu);
    check("res_valid", res_valid, exp_v);
    check("illegal_op", illegal_op, m_ill);
    if (exp_v) check("alu_result", alu_pipe[ALU_LAT-1], exp_r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    flush = 0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_alu_ops", {alu_opcode, alu_a, alu_b}, {4'hF, 16'h0});
    check("rst_res_valid", res_valid, 0);
    check("rst_illegal", illegal_op, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 4'h0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    model_clear();
    do_reset();
    cycle(1, 4'h0, 8'h05, 8'h03, 0);
    idle(6);
    for (int i = 0; i < 5; i++) cycle(1, 4'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), 0);
    idle(5);
    for (int i = 0; i < 16; i++) cycle(1, 4'h1, 8'(i + 10), 8'(i), 0);
    idle(5);
    for (int i = 0; i < 3; i++) cycle(1, 4'h0, 8'(i), 8'h01, 0);
    cycle(1, 4'h2, 8'hFF, 8'h0F, 1);
    idle(6);
    for (int i = 0; i < 4; i++) cycle(1, 4'h0, 8'(i), 8'h02, 0);
    do_reset();
    idle(6);
    cycle(1, 4'h9, 8'h12, 8'h34, 0);
    idle(5);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
